arbiter_rr_n: RTL
=================

Name: arbiter_rr_n

Overview:
- Parametrised N-requester arbiter; next generation of the 2-requester arbiter.
- Adds round-robin fairness, a selectable fixed-priority mode, grant locking while the owner keeps requesting, and a bounded hold time.
- Sits between N bus masters and a single shared resource.
- Verified by its own top/testbench pair with a free-running clock.

Parameters:
- N, 4, number of requesters (2..16).
- MAX_HOLD, 8, max consecutive grant cycles per owner while others wait; 0 = unlimited hold.
- IDW, $clog2(N), width of grant_id (derived, not overridden).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous active-low reset
- request  input  N  request[i]=1 means requester i wants the resource; level, held until served
- mode  input  1  0 = round-robin, 1 = fixed priority (index 0 highest)
- grant  output  N  one-hot registered grant, or all-zero
- grant_valid  output  1  OR of grant, registered
- grant_id  output  IDW  index of granted requester; 0 when grant_valid=0

Behaviour:
- Reset (rst=0, async): grant=0, grant_valid=0, grant_id=0, rr pointer=0 (requester 0 highest), hold counter=0, FSM=IDLE. Reset mid-grant drops grant immediately without waiting for a clock edge. First arbitration is on the first rising edge after rst deasserts.
- FSM has two states, IDLE and BUSY.
- IDLE:
  - request==0: stay IDLE.
  - Otherwise arbitrate, register grant, go to BUSY.
  - Latency: request sampled at edge t gives grant visible after edge t; one cycle request-to-grant.
- BUSY, owner o, hold count h. h=1 in the first grant cycle and increments each cycle the grant is kept, saturating at MAX_HOLD.
  - request[o]=0 at an edge: release and re-arbitrate on the same edge, with no idle bubble. If no requests remain: grant=0, go to IDLE.
  - request[o]=1, MAX_HOLD≠0, h==MAX_HOLD, other requests pending: pre-empt. Re-arbitrate with o excluded; the new owner gets h=1.
  - request[o]=1, h==MAX_HOLD, no other requests: keep o, restart h=1.
  - Otherwise keep o; the grant is stable.
- Arbitration:
  - Round-robin: winner is the first set request scanning ptr, ptr+1, …, N-1, 0, …, ptr-1 (wrap-around).
  - Fixed priority: winner is the lowest set index.
  - In both modes, after granting w, ptr ← (w+1) mod N; after w=N-1, ptr wraps to 0.
- mode is sampled only at arbitration edges. Changing mode during BUSY does not disturb the current owner.
- Invariants:
  - grant is always one-hot or zero.
  - grant_id and grant_valid always agree with grant.
  - A requester is granted only if its request was 1 at the granting edge.
- Simultaneous events:
  - Owner drops while others raise on the same edge: the others are arbitrated on that edge.
  - A newly raised request on the release edge is eligible.
- Starvation bound (round-robin, MAX_HOLD≠0): a waiting requester is granted within (N-1)·MAX_HOLD+1 cycles.
- Request drops by non-owners have no effect. X on request during reset is ignored.
- Implementation: registered outputs only; no combinational path from request to grant.

Test Plan:
- Reset and first grant: rst=0 then 1, request=4'b0000 for 3 cycles → grant=0, grant_valid=0. Then request=4'b0100 → next cycle grant=4'b0100, grant_id=2.
- Round-robin rotation: mode=0, request=4'b1111. Each owner drops its request after 2 cycles, then re-raises it → grant sequence 0001,0010,0100,1000,0001 (wrap), each held 2 cycles, no idle cycles.
- Fixed priority: mode=1, request=4'b1010, owner 1 drops then re-raises after 1 cycle → grant 0010 → 1000 → 0010. Index 3 is served only when index 1 is low.
- Hold limit: MAX_HOLD=8, request[0] held high continuously, request[3] raised at cycle 2 → grant=0001 for exactly 8 cycles, then 1000. With request[3] low throughout, 0001 is held indefinitely.
- Async reset mid-grant: grant=0010 in BUSY, rst pulsed low between clock edges → grant=0 immediately. After release with request=4'b0011 → grant=0001 (pointer back to 0).
- Randomized soak: 10k cycles of random request/mode. Assertions hold for one-hot grant, grant_id consistency, the starvation bound and one-cycle latency.

Source files
------------

// File: rtl/arbiter_rr_n.sv
// rtl/arbiter_rr_n.sv - N-requester round-robin / fixed-priority arbiter with grant locking and bounded hold
module arbiter_rr_n #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  localparam int IDW     = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   request,
  input  logic           mode,
  output logic [N-1:0]   grant,
  output logic           grant_valid,
  output logic [IDW-1:0] grant_id
);

  localparam int HW = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   grant_q, grant_d;
  logic           grant_valid_q, grant_valid_d;
  logic [IDW-1:0] grant_id_q, grant_id_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [HW-1:0]  hold_q, hold_d;

  logic           arb_en;
  logic [N-1:0]   arb_req;
  logic [IDW:0]   arb_res;
  logic [IDW-1:0] arb_win;
  logic           owner_req;
  logic           others_req;

  // Returns {found, winner}; round-robin scans from ptr with wrap, fixed mode scans from index 0.
  function automatic logic [IDW:0] pick(input logic [N-1:0] req, input logic [IDW-1:0] ptr,
                                        input logic fixed);
    logic           found;
    logic [IDW-1:0] win;
    int             idx;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < N; k++) begin
      idx = fixed ? k : (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
    return {found, win};
  endfunction

  // Next-state: decide whether to keep the owner, pre-empt it, or re-arbitrate, then load the winner.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    grant_valid_d = grant_valid_q;
    grant_id_d    = grant_id_q;
    ptr_d         = ptr_q;
    hold_d        = hold_q;
    arb_en        = 1'b0;
    arb_req       = request;
    owner_req     = |(request & grant_q);
    others_req    = |(request & ~grant_q);

    case (state_q)
      IDLE: begin
        if (|request) arb_en = 1'b1;
      end
      BUSY: begin
        if (!owner_req) begin
          // Owner released: hand over on this same edge, or fall back to idle.
          arb_en = 1'b1;
        end else if ((MAX_HOLD != 0) && (hold_q == HOLD_MAX)) begin
          if (others_req) begin
            // Hold budget spent with others waiting: exclude the owner from this round.
            arb_en  = 1'b1;
            arb_req = request & ~grant_q;
          end else begin
            hold_d = HW'(1);
          end
        end else if (MAX_HOLD != 0) begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    arb_res = pick(arb_req, ptr_q, mode);
    arb_win = arb_res[IDW-1:0];

    if (arb_en) begin
      if (arb_res[IDW]) begin
        state_d       = BUSY;
        grant_valid_d = 1'b1;
        grant_id_d    = arb_win;
        hold_d        = HW'(1);
        ptr_d         = (arb_win == IDW'(N - 1)) ? '0 : arb_win + IDW'(1);
        for (int i = 0; i < N; i++) grant_d[i] = (arb_win == IDW'(i));
      end else begin
        state_d       = IDLE;
        grant_d       = '0;
        grant_valid_d = 1'b0;
        grant_id_d    = '0;
        hold_d        = '0;
      end
    end
  end

  // State and registered outputs; reset drops the grant without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      ptr_q         <= '0;
      hold_q        <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      grant_id_q    <= grant_id_d;
      ptr_q         <= ptr_d;
      hold_q        <= hold_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;

endmodule
